// File: rtl/layer_output_packer_if.sv
// Handshake bundle between the serialized output layer (master) and the
// output packer (slave). The packer's outputs feed the argmax stage.
interface layer_output_packer_if #(
  parameter int data_width = 16,
  parameter int no_inputs  = 10
);
  logic                              valid_input;
  logic [data_width-1:0]             data_in;
  logic                              last_input;
  logic                              valid_output;
  logic [data_width*no_inputs-1:0]   my_output;
  logic                              frame_error;
  logic [31:0]                       element_count;

  modport master (
    output valid_input, data_in, last_input,
    input  valid_output, my_output, frame_error, element_count
  );

  modport slave (
    input  valid_input, data_in, last_input,
    output valid_output, my_output, frame_error, element_count
  );
endinterface

// File: rtl/layer_output_packer.sv
// Serial-to-parallel packer: gathers no_inputs score words into one frame,
// checks alignment against last_input, and strobes the finished frame.
// Optional macro PACKER_RELU_EN: clamp negative (two's-complement) scores
// to zero before storing them.
module layer_output_packer #(
  parameter int data_width = 16,
  parameter int no_inputs  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  layer_output_packer_if.slave bus
);
  localparam int idx_w = (no_inputs > 2) ? $clog2(no_inputs) : 1;
  localparam logic [31:0] last_idx = 32'(no_inputs - 1);

  logic [data_width-1:0]           work_buf [no_inputs-1];
  logic [31:0]                     cnt_q;
  logic [data_width-1:0]           elem_in;
  logic [data_width*no_inputs-1:0] frame_next;
  logic [data_width*no_inputs-1:0] out_q;
  logic                            valid_q;
  logic                            err_q;
  logic                            at_last_slot;

`ifdef PACKER_RELU_EN
  assign elem_in = bus.data_in[data_width-1] ? '0 : bus.data_in;
`else
  assign elem_in = bus.data_in;
`endif

  assign at_last_slot = (cnt_q == last_idx);

  // Full frame as it would look if the current word completes it.
  always_comb begin
    frame_next = '0;
    for (int k = 0; k < no_inputs - 1; k++) begin
      frame_next[k*data_width +: data_width] = work_buf[k];
    end
    frame_next[(no_inputs-1)*data_width +: data_width] = elem_in;
  end

  // Working buffer holds partial-frame slots; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (bus.valid_input && !at_last_slot && !bus.last_input) begin
      work_buf[cnt_q[idx_w-1:0]] <= elem_in;
    end
  end

  // Element counter, frame register and one-cycle status strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (bus.valid_input) begin
        if (at_last_slot) begin
          cnt_q <= '0;
          if (bus.last_input) begin
            out_q   <= frame_next;
            valid_q <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
        end else if (bus.last_input) begin
          cnt_q <= '0;
          err_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 32'd1;
        end
      end
    end
  end

  assign bus.valid_output  = valid_q;
  assign bus.frame_error   = err_q;
  assign bus.my_output     = out_q;
  assign bus.element_count = cnt_q;
endmodule

// File: tb/tb_layer_output_packer.sv
// Randomized and directed bench for layer_output_packer with a queue-based
// reference model of frame assembly.
module tb_layer_output_packer;
  localparam int DW = 16;
  localparam int N  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  layer_output_packer_if #(.data_width(DW), .no_inputs(N)) bus ();

  layer_output_packer #(.data_width(DW), .no_inputs(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0]   q [$];
  logic [DW*N-1:0] exp_out   = '0;
  logic            exp_valid = 1'b0;
  logic            exp_err   = 1'b0;
  int              exp_cnt   = 0;

  function automatic logic [DW-1:0] clamp(input logic [DW-1:0] d);
`ifdef PACKER_RELU_EN
    if ($signed(d) < 0) return '0;
`endif
    return d;
  endfunction

  // Applies one cycle of input and advances the model; sampling point is 1ns after the edge.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic l);
    bus.valid_input = v;
    bus.data_in     = d;
    bus.last_input  = l;
    @(posedge clk);
    #1;
    cyc++;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (v) begin
      q.push_back(clamp(d));
      if (l || q.size() == N) begin
        if (l && q.size() == N) begin
          for (int k = 0; k < N; k++) exp_out[k*DW +: DW] = q[k];
          exp_valid = 1'b1;
        end else begin
          exp_err = 1'b1;
        end
        q.delete();
      end
    end
    exp_cnt = q.size();
    bus.valid_input = 1'b0;
    bus.data_in     = '0;
    bus.last_input  = 1'b0;
  endtask

  task automatic test_reset();
    bus.valid_input = 1'b0;
    bus.data_in     = '0;
    bus.last_input  = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.valid_output !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.valid_output); end
    total++; if (bus.frame_error !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.frame_error); end
    total++; if (bus.my_output !== '0) begin bad++; $display("FAIL reset_out got=%h want=0", bus.my_output); end
    total++; if (bus.element_count !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", bus.element_count); end
    rst = 1'b0;
    q.delete();
    exp_out = '0;
  endtask

  task automatic test_single_frame();
    for (int i = 1; i <= N; i++) begin
      drive(1'b1, DW'(i), i == N);
      if (i == 5) begin
        total++; if (bus.element_count !== 32'd5) begin bad++; $display("FAIL single_midcnt got=%0d want=5", bus.element_count); end
      end
    end
    total++; if (bus.valid_output !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", bus.valid_output); end
    total++; if (bus.my_output[15:0] !== 16'h0001) begin bad++; $display("FAIL single_slot0 got=%h want=0001", bus.my_output[15:0]); end
    total++; if (bus.my_output[159:144] !== 16'h000A) begin bad++; $display("FAIL single_slot9 got=%h want=000a", bus.my_output[159:144]); end
    total++; if (bus.element_count !== 32'd0) begin bad++; $display("FAIL single_cnt got=%0d want=0", bus.element_count); end
    drive(1'b0, '0, 1'b0);
    total++; if (bus.valid_output !== 1'b0) begin bad++; $display("FAIL single_pulse_len got=%b want=0", bus.valid_output); end
  endtask

  task automatic test_back_to_back();
    int pulses [$];
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < N; i++) begin
        drive(1'b1, DW'(f == 0 ? 16'h0020 + i : 16'h0100 + i), i == N - 1);
        if (bus.valid_output) pulses.push_back(cyc);
      end
    end
    total++; if (pulses.size() != 2) begin bad++; $display("FAIL b2b_pulses got=%0d want=2", pulses.size()); end
    else begin
      total++; if (pulses[1] - pulses[0] != N) begin bad++; $display("FAIL b2b_gap got=%0d want=%0d", pulses[1] - pulses[0], N); end
    end
    total++; if (bus.my_output[15:0] !== 16'h0100) begin bad++; $display("FAIL b2b_slot0 got=%h want=0100", bus.my_output[15:0]); end
    total++; if (bus.my_output !== exp_out) begin bad++; $display("FAIL b2b_frame got=%h want=%h", bus.my_output, exp_out); end
  endtask

  task automatic test_early_last();
    logic [DW*N-1:0] prior;
    prior = exp_out;
    for (int i = 0; i < 4; i++) drive(1'b1, DW'(16'h0300 + i), i == 3);
    total++; if (bus.frame_error !== 1'b1) begin bad++; $display("FAIL early_err got=%b want=1", bus.frame_error); end
    total++; if (bus.valid_output !== 1'b0) begin bad++; $display("FAIL early_valid got=%b want=0", bus.valid_output); end
    total++; if (bus.my_output !== prior) begin bad++; $display("FAIL early_hold got=%h want=%h", bus.my_output, prior); end
    total++; if (bus.element_count !== 32'd0) begin bad++; $display("FAIL early_cnt got=%0d want=0", bus.element_count); end
    for (int i = 0; i < N; i++) drive(1'b1, DW'(16'h0400 + i), i == N - 1);
    total++; if (bus.valid_output !== 1'b1 || bus.my_output !== exp_out) begin
      bad++; $display("FAIL early_recover got=%b/%h want=1/%h", bus.valid_output, bus.my_output, exp_out);
    end
  endtask

  task automatic test_missing_last();
    logic [DW*N-1:0] prior;
    prior = exp_out;
    for (int i = 0; i < N; i++) drive(1'b1, DW'(16'h0500 + i), 1'b0);
    total++; if (bus.frame_error !== 1'b1) begin bad++; $display("FAIL miss_err got=%b want=1", bus.frame_error); end
    total++; if (bus.valid_output !== 1'b0) begin bad++; $display("FAIL miss_valid got=%b want=0", bus.valid_output); end
    total++; if (bus.my_output !== prior) begin bad++; $display("FAIL miss_hold got=%h want=%h", bus.my_output, prior); end
    total++; if (bus.element_count !== 32'd0) begin bad++; $display("FAIL miss_cnt got=%0d want=0", bus.element_count); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, DW'(16'h0600 + i), 1'b0);
    #3 rst = 1'b1;
    #1;
    total++; if (bus.my_output !== '0) begin bad++; $display("FAIL arst_out got=%h want=0", bus.my_output); end
    total++; if (bus.element_count !== 32'd0) begin bad++; $display("FAIL arst_cnt got=%0d want=0", bus.element_count); end
    total++; if (bus.valid_output !== 1'b0 || bus.frame_error !== 1'b0) begin
      bad++; $display("FAIL arst_strobes got=%b%b want=00", bus.valid_output, bus.frame_error);
    end
    q.delete();
    exp_out = '0;
    exp_cnt = 0;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) drive(1'b1, DW'(16'h0700 + i), i == N - 1);
    total++; if (bus.valid_output !== 1'b1) begin bad++; $display("FAIL arst_next_valid got=%b want=1", bus.valid_output); end
    total++; if (bus.my_output[15:0] !== 16'h0700 || bus.my_output !== exp_out) begin
      bad++; $display("FAIL arst_next_frame got=%h want=%h", bus.my_output, exp_out);
    end
  endtask

  task automatic test_relu();
    logic [15:0] want3;
`ifdef PACKER_RELU_EN
    want3 = 16'h0000;
`else
    want3 = 16'hFFF0;
`endif
    for (int i = 0; i < N; i++) drive(1'b1, (i == 3) ? 16'hFFF0 : DW'(16'h0800 + i), i == N - 1);
    total++; if (bus.my_output[63:48] !== want3) begin bad++; $display("FAIL relu_slot3 got=%h want=%h", bus.my_output[63:48], want3); end
    total++; if (bus.my_output[47:32] !== 16'h0802) begin bad++; $display("FAIL relu_slot2 got=%h want=0802", bus.my_output[47:32]); end
  endtask

  task automatic test_random();
    logic v, l;
    logic [DW-1:0] d;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      d = DW'($urandom);
      if (q.size() == N - 1) l = ($urandom_range(0, 7) != 0);
      else                   l = ($urandom_range(0, 19) == 0);
      drive(v, d, l);
      total++;
      if (bus.valid_output !== exp_valid || bus.frame_error !== exp_err ||
          bus.element_count !== 32'(exp_cnt) || bus.my_output !== exp_out) begin
        bad++;
        $display("FAIL rand_cyc%0d got v=%b e=%b c=%0d out=%h want v=%b e=%b c=%0d out=%h", i,
                 bus.valid_output, bus.frame_error, bus.element_count, bus.my_output,
                 exp_valid, exp_err, exp_cnt, exp_out);
      end
      total++;
      if (bus.valid_output === 1'b1 && bus.frame_error === 1'b1) begin
        bad++; $display("FAIL rand_exclusive cyc%0d got both=1 want not both", i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_early_last();
    test_missing_last();
    test_async_reset();
    test_relu();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
